// File: rtl/ex.sv
// Execute stage: RV32I ALU, branch/jump resolution and a 33-cycle restoring divider.
// Outputs are combinational; the divider holds the pipeline while BUSY.
module ex (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        reg_wen_i,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic        rd_wen_o,
  output logic [31:0] jump_addr_o,
  output logic        jump_en_o,
  output logic        hold_flag_o
);

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

  div_state_t  state;
  logic [31:0] dvd_q;     // dividend shifting out, quotient shifting in
  logic [31:0] dvs_q;
  logic [31:0] rem_q;
  logic [4:0]  cnt_q;
  logic        neg_quo_q;
  logic        neg_rem_q;
  logic        sel_rem_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_b;
  logic [31:0] imm_j;
  logic        is_div;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];
  assign imm_i  = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_b  = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_j  = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign is_div = (opcode == OPC_OP) && (funct7 == 7'b0000001) && funct3[2];

  // Operand conditioning for a divide presented this cycle
  logic        div_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_abs;
  logic [31:0] b_abs;

  assign div_signed = ~funct3[0];
  assign a_neg      = div_signed & op1_i[31];
  assign b_neg      = div_signed & op2_i[31];
  assign a_abs      = a_neg ? -op1_i : op1_i;
  assign b_abs      = b_neg ? -op2_i : op2_i;

  // One restoring step: shift in the next dividend bit, subtract if it fits
  logic [32:0] rem_shift;
  logic [32:0] rem_diff;
  logic        rem_ge;

  assign rem_shift = {rem_q, dvd_q[31]};
  assign rem_diff  = rem_shift - {1'b0, dvs_q};
  assign rem_ge    = ~rem_diff[32];

  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] div_res;

  assign quo_fix = neg_quo_q ? -dvd_q : dvd_q;
  assign rem_fix = neg_rem_q ? -rem_q : rem_q;
  assign div_res = sel_rem_q ? rem_fix : quo_fix;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      sel_rem_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (is_div) begin
            dvd_q     <= a_abs;
            dvs_q     <= b_abs;
            rem_q     <= '0;
            cnt_q     <= '0;
            // A zero divisor must yield all-ones quotient, so never negate it
            neg_quo_q <= (a_neg ^ b_neg) & (op2_i != 32'd0);
            neg_rem_q <= a_neg;
            sel_rem_q <= funct3[1];
            state     <= BUSY;
          end
        end
        BUSY: begin
          rem_q <= rem_ge ? rem_diff[31:0] : rem_shift[31:0];
          dvd_q <= {dvd_q[30:0], rem_ge};
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  alu = alt ? (a - b) : (a + b);
      3'b001:  alu = a << b[4:0];
      3'b010:  alu = {31'd0, $signed(a) < $signed(b)};
      3'b011:  alu = {31'd0, a < b};
      3'b100:  alu = a ^ b;
      3'b101:  alu = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'b110:  alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  logic br_taken;

  always_comb begin
    case (funct3)
      3'b000:  br_taken = (op1_i == op2_i);
      3'b001:  br_taken = (op1_i != op2_i);
      3'b100:  br_taken = $signed(op1_i) <  $signed(op2_i);
      3'b101:  br_taken = $signed(op1_i) >= $signed(op2_i);
      3'b110:  br_taken = op1_i <  op2_i;
      3'b111:  br_taken = op1_i >= op2_i;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    rd_addr_o   = '0;
    rd_data_o   = '0;
    rd_wen_o    = 1'b0;
    jump_addr_o = '0;
    jump_en_o   = 1'b0;
    hold_flag_o = 1'b0;
    if (rst) begin
      rd_addr_o = rd_addr_i;
      case (state)
        BUSY: hold_flag_o = 1'b1;
        DONE: begin
          rd_data_o = div_res;
          rd_wen_o  = reg_wen_i;
        end
        default: begin
          case (opcode)
            OPC_OPIMM: begin
              rd_data_o = alu(funct3, (funct3 == 3'b101) & inst_i[30], op1_i, op2_i);
              rd_wen_o  = reg_wen_i;
            end
            OPC_OP: begin
              if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
                rd_data_o = alu(funct3, inst_i[30], op1_i, op2_i);
                rd_wen_o  = reg_wen_i;
              end else if (is_div) begin
                hold_flag_o = 1'b1;
              end
            end
            OPC_BRANCH: begin
              if (br_taken) begin
                jump_en_o   = 1'b1;
                jump_addr_o = inst_addr_i + imm_b;
              end
            end
            OPC_JAL: begin
              rd_data_o   = inst_addr_i + 32'd4;
              rd_wen_o    = reg_wen_i;
              jump_en_o   = 1'b1;
              jump_addr_o = inst_addr_i + imm_j;
            end
            OPC_JALR: begin
              rd_data_o   = inst_addr_i + 32'd4;
              rd_wen_o    = reg_wen_i;
              jump_en_o   = 1'b1;
              jump_addr_o = (op1_i + imm_i) & ~32'd1;
            end
            default: ;
          endcase
        end
      endcase
    end
  end

endmodule

// File: doc/ex.md
EX -- requirements
Module: ex

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 32 bits.
REQ-002 The block SHALL have one clock and a synchronous, active-low reset, with ports as follows:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset.
REQ-003 The block SHALL have these ports from the ID/EX register:
- inst_i       input  32  instruction.
- inst_addr_i  input  32  instruction PC.
- op1_i        input  32  rs1 value.
- op2_i        input  32  rs2 value, or immediate for OP-IMM.
- rd_addr_i    input  5   destination register.
- reg_wen_i    input  1   write request from decode.
REQ-004 The block SHALL have these ports to the register file:
- rd_addr_o  output  5   write address.
- rd_data_o  output  32  write data.
- rd_wen_o   output  1   write enable.
REQ-005 The block SHALL have these ports to the control unit:
- jump_addr_o  output  32  redirect target.
- jump_en_o    output  1   redirect and flush of IF/ID and ID/EX.
- hold_flag_o  output  1   freeze PC, IF/ID and ID/EX.

Function
REQ-006 Outputs SHALL be combinational from the inputs and divider state; the only storage SHALL be the divider datapath and its FSM.
REQ-007 rd_addr_o SHALL equal rd_addr_i whenever rst is high.
REQ-008 OP-IMM (ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI) and OP with funct7 0000000/0100000 (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND) SHALL behave as follows:
- rd_data_o = RV32I result of op1_i and op2_i.
- Shift amount = op2_i[4:0]; SRAI/SRA are selected by inst_i[30].
- rd_wen_o = reg_wen_i, in the same cycle.
REQ-009 Branches (BEQ, BNE, BLT, BGE, BLTU, BGEU) SHALL compare op1_i with op2_i (signed/unsigned per funct3).
- If taken: jump_en_o = 1 and jump_addr_o = inst_addr_i + sign-extended B-immediate decoded from inst_i.
- rd_wen_o = 0.
REQ-010 JAL SHALL drive rd_data_o = inst_addr_i + 4, rd_wen_o = reg_wen_i, jump_en_o = 1 and jump_addr_o = inst_addr_i + J-immediate.
REQ-011 JALR SHALL behave as JAL, except jump_addr_o = (op1_i + I-immediate) with bit 0 cleared.
REQ-012 Unsupported opcodes, and OP with funct7 0000001 and funct3 000–011 (MUL family), SHALL drive rd_wen_o = 0, jump_en_o = 0, hold_flag_o = 0 and rd_data_o = 0.
REQ-013 When neither jumping nor holding, the block SHALL drive jump_addr_o = 0.
REQ-014 DIV, DIVU, REM and REMU (OP, funct7 0000001, funct3 100–111) SHALL use a 32-iteration restoring divider FSM with states IDLE, BUSY and DONE.
REQ-015 In IDLE, when a divide is present in cycle T, the block SHALL:
- latch the operands, sign handling and result select;
- clear the 5-bit counter;
- assert hold_flag_o in T with rd_wen_o = 0;
- move to BUSY.
REQ-016 BUSY SHALL perform one quotient bit per cycle for 32 cycles (T+1..T+32) with hold_flag_o = 1 and rd_wen_o = 0, then move to DONE when the counter wraps from 31.
REQ-017 In DONE (T+33) the block SHALL drive the result, rd_wen_o = reg_wen_i and hold_flag_o = 0, then move to IDLE.
- The quotient or remainder SHALL be sign-corrected for DIV/REM.
- The latency from divide presentation to writeback SHALL be exactly 33 cycles.
REQ-018 The divide special cases SHALL be:
- Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend.
- Signed 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- Special cases SHALL keep the same 33-cycle latency.
REQ-019 A divide SHALL NOT restart in the IDLE cycle that follows DONE.
- The ID/EX register has advanced by then, since hold was low in DONE.
- A back-to-back divide SHALL therefore start at T+34.
REQ-020 While the FSM is BUSY or DONE, the block SHALL use the latched operands and ignore changes on op1_i/op2_i.
REQ-021 The block SHALL never assert jump_en_o and hold_flag_o in the same cycle.

Reset
REQ-022 While rst is 0 at a clock edge, the FSM SHALL return to IDLE and the counter and divider registers SHALL clear to 0.
REQ-023 While rst is 0, all outputs SHALL be forced to 0.
REQ-024 A reset during BUSY or DONE SHALL abandon the divide with no write, and the FSM SHALL be IDLE on the first cycle after rst returns high.

Verification
REQ-025 The bench SHALL cover at least these directed scenarios:
- ADD, op1 = 0x7FFFFFFF, op2 = 1, rd = 5 -> same cycle rd_data_o = 0x80000000, rd_wen_o = 1, rd_addr_o = 5.
- BEQ at PC 0x100, imm = -8, op1 = op2 = 3 -> jump_en_o = 1, jump_addr_o = 0xF8; with op1 = 4 -> jump_en_o = 0.
- DIV with op1 = -7, op2 = 2 at T -> hold_flag_o = 1 for T..T+32; at T+33 rd_data_o = 0xFFFFFFFD, rd_wen_o = 1, hold_flag_o = 0; REM gives 0xFFFFFFFF.
- DIVU by 0 and DIV 0x80000000 / -1 -> 0xFFFFFFFF and 0x80000000 respectively, both at T+33.
- rst low at T+10 of a divide -> outputs 0; after release, an ADD completes normally and no stale division write occurs.
- Two divides back-to-back -> writebacks at T+33 and T+67, with hold_flag_o low only in the DONE cycles.
